// File: rtl/hidden_layer_sequencer.sv
// Hidden-layer sequencer: walks the MAC through one weight window per neuron, activates each
// dot-product sum (sign-magnitude Q3.12) and latches it into the hidden-layer register array.
module hidden_layer_sequencer #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned ACT_TYPE    = 0,
  parameter int unsigned SLACK       = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          count_done_o,
  output logic                          mac_run_o,
  output logic signed [31:0]            mac_start_o,
  output logic signed [31:0]            mac_size_o,
  input  logic                          mac_done_i,
  input  logic [15:0]                   mac_out_i,
  output logic [NUM_NEURONS-1:0][15:0]  hidden_out_o
);

  localparam int unsigned NW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned RunMax = 4 * NUM_INPUTS + SLACK - 1;
  localparam int unsigned CW     = $clog2(RunMax + 1);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StAct, StStore, StDone} state_e;

  state_e                        state_q, state_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [CW-1:0]                 runcnt_q, runcnt_d;
  logic                          count_done_q, count_done_d;
  logic [15:0]                   act_q, act_d;
  logic [NUM_NEURONS-1:0][15:0]  hidden_q, hidden_d;

  // ReLU or hard sigmoid on a sign-magnitude Q3.12 value; result is always non-negative.
  function automatic logic [15:0] activate(input logic [15:0] x);
    logic [12:0] m;
    logic [13:0] sum;
    logic [15:0] y;
    m   = x[14:2];
    sum = 14'h0800 + {1'b0, m};
    if (ACT_TYPE == 0) begin
      y = x[15] ? 16'h0000 : x;
    end else if (!x[15]) begin
      y = (sum >= 14'h1000) ? 16'h1000 : {2'b00, sum};
    end else begin
      y = (m >= 13'h0800) ? 16'h0000 : (16'h0800 - {3'b000, m});
    end
    return y;
  endfunction

  // State and datapath registers; reset aborts any frame and clears the hidden array.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      n_q          <= '0;
      runcnt_q     <= '0;
      count_done_q <= 1'b0;
      act_q        <= '0;
      hidden_q     <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      runcnt_q     <= runcnt_d;
      count_done_q <= count_done_d;
      act_q        <= act_d;
      hidden_q     <= hidden_d;
    end
  end

  // Next-state logic: ARM reloads the MAC, RUN waits for completion or timeout, ACT/STORE commit.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    runcnt_d     = runcnt_q;
    count_done_d = count_done_q;
    act_d        = act_q;
    hidden_d     = hidden_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d      = StArm;
          n_d          = '0;
          count_done_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StArm: begin
        state_d  = StRun;
        runcnt_d = '0;
      end
      StRun: begin
        // A done flag in the first two RUN cycles may be stale from the previous window.
        if (mac_done_i && (runcnt_q >= CW'(2))) begin
          state_d = StAct;
        end else if (runcnt_q == CW'(RunMax)) begin
          state_d      = StAct;
          count_done_d = 1'b1;
        end else begin
          runcnt_d = runcnt_q + CW'(1);
        end
      end
      StAct: begin
        act_d   = activate(mac_out_i);
        state_d = StStore;
      end
      StStore: begin
        hidden_d[n_q] = act_q;
        if (n_q == NW'(NUM_NEURONS - 1)) begin
          state_d = StDone;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = StArm;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    busy_o       = (state_q == StArm) || (state_q == StRun) ||
                   (state_q == StAct) || (state_q == StStore);
    done_o       = (state_q == StDone);
    mac_run_o    = (state_q == StRun);
    count_done_o = count_done_q;
    mac_start_o  = $signed(32'(n_q) * 32'(NUM_INPUTS));
    mac_size_o   = $signed(32'(NUM_INPUTS));
    hidden_out_o = hidden_q;
  end

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Bench for hidden_layer_sequencer: a ReLU instance (3 neurons) and a hard-sigmoid instance
// (4 neurons), each fed by a simple MAC model whose sum depends on the requested window.
module tb_hidden_layer_sequencer;
  localparam int NI = 4;
  localparam int SL = 8;
  localparam int NA = 3;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          start = 2'b00;
  logic [1:0]          busy, done, cd, run, mdone;
  logic signed [31:0]  mstart[2];
  logic signed [31:0]  msize[2];
  logic [15:0]         mout[2];
  logic [NA-1:0][15:0] hid_a;
  logic [NB-1:0][15:0] hid_b;

  logic [15:0] vals[2][4];
  int          dly[2];
  int          cnt[2];
  int          n_cmp = 0;
  int          n_err = 0;

  hidden_layer_sequencer #(.NUM_NEURONS(NA), .NUM_INPUTS(NI), .ACT_TYPE(0), .SLACK(SL)) u_a (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .count_done_o(cd[0]), .mac_run_o(run[0]), .mac_start_o(mstart[0]), .mac_size_o(msize[0]),
    .mac_done_i(mdone[0]), .mac_out_i(mout[0]), .hidden_out_o(hid_a)
  );

  hidden_layer_sequencer #(.NUM_NEURONS(NB), .NUM_INPUTS(NI), .ACT_TYPE(1), .SLACK(SL)) u_b (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .count_done_o(cd[1]), .mac_run_o(run[1]), .mac_start_o(mstart[1]), .mac_size_o(msize[1]),
    .mac_done_i(mdone[1]), .mac_out_i(mout[1]), .hidden_out_o(hid_b)
  );

  // MAC model: counts cycles of mac_run, raises done after dly cycles (dly < 0: never).
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) cnt[s] <= run[s] ? cnt[s] + 1 : 0;
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      mdone[s] = run[s] && (dly[s] >= 0) && (cnt[s] >= dly[s]);
      mout[s]  = vals[s][(mstart[s] / NI) % 4];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference activation from the numeric definition.
  function automatic logic [15:0] act_ref(input int typ, input logic [15:0] x);
    int mag;
    int y;
    mag = int'(x[14:0]);
    if (typ == 0) begin
      y = x[15] ? 0 : mag;
    end else begin
      y = x[15] ? 2048 - mag / 4 : 2048 + mag / 4;
      if (y < 0) y = 0;
      if (y > 4096) y = 4096;
    end
    return 16'(y);
  endfunction

  function automatic logic [15:0] get_h(input int sel, input int k);
    logic [1:0] i;
    i = k[1:0];
    return (sel == 0) ? hid_a[i] : hid_b[i];
  endfunction

  // One frame: pre = start already driven in a DONE cycle; chain = drive start in this DONE cycle.
  task automatic run_frame(input int sel, input bit pre, input bit chain, input string tag);
    int          nn, r, lat, k, runs, runlen;
    bit          prev_run, cd_exp;
    logic [31:0] last_start;
    nn     = (sel == 0) ? NA : NB;
    r      = (dly[sel] < 0) ? 4 * NI + SL : ((dly[sel] < 2) ? 2 : dly[sel]) + 1;
    lat    = nn * (r + 3) + 1;
    cd_exp = (dly[sel] < 0);
    if (!pre) begin
      @(negedge clk);
      start[sel] = 1'b1;
    end
    runs = 0; runlen = 0; prev_run = 1'b0; last_start = 0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start[sel] = 1'b0;
        check($sformatf("%s busy_after_start", tag), busy[sel], 1);
        check($sformatf("%s count_done_cleared", tag), cd[sel], 0);
      end
      if (run[sel] && !prev_run) begin
        check($sformatf("%s arm_mac_start%0d", tag, runs), last_start, runs * NI);
        runs++;
        runlen = 0;
      end
      if (run[sel]) runlen++;
      if (!run[sel] && prev_run) check($sformatf("%s run_len", tag), runlen, r);
      if (!run[sel]) last_start = mstart[sel];
      prev_run = run[sel];
    end while (k < lat + 20 && !done[sel]);
    check($sformatf("%s latency", tag), k, lat);
    check($sformatf("%s run_count", tag), runs, nn);
    check($sformatf("%s count_done", tag), cd[sel], cd_exp);
    check($sformatf("%s busy_at_done", tag), busy[sel], 0);
    for (int i = 0; i < nn; i++)
      check($sformatf("%s hidden%0d", tag, i), get_h(sel, i), act_ref(sel, vals[sel][i]));
    if (chain) begin
      start[sel] = 1'b1;
    end else begin
      @(negedge clk);
      check($sformatf("%s done_single_pulse", tag), done[sel], 0);
      check($sformatf("%s hidden0_held", tag), get_h(sel, 0), act_ref(sel, vals[sel][0]));
    end
  endtask

  typedef struct {
    int          sel;
    int          d;
    logic [15:0] v[4];
    logic [15:0] e[4];
  } vec_t;

  vec_t tbl[5];

  initial begin
    int ndone, k, r;
    tbl[0] = '{0, 16, '{16'h9000, 16'h1800, 16'h8000, 16'h0000}, '{16'h0000, 16'h1800, 16'h0000, 16'h0000}};
    tbl[1] = '{1, 16, '{16'h2000, 16'h8800, 16'h0400, 16'hF000}, '{16'h1000, 16'h0600, 16'h0900, 16'h0000}};
    tbl[2] = '{1, 0,  '{16'h8000, 16'h7FFF, 16'h0000, 16'h8003}, '{16'h0800, 16'h1000, 16'h0800, 16'h0800}};
    tbl[3] = '{0, -1, '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000}, '{16'h0001, 16'h0000, 16'h7FFF, 16'h0000}};
    tbl[4] = '{1, 2,  '{16'h1FFC, 16'h2004, 16'h9FFC, 16'hA000}, '{16'h0FFF, 16'h1000, 16'h0001, 16'h0000}};
    for (int s = 0; s < 2; s++) begin
      dly[s] = 16;
      for (int i = 0; i < 4; i++) vals[s][i] = '0;
    end

    // Reset held, then released.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d busy", s), busy[s], 0);
      check($sformatf("rst%0d done", s), done[s], 0);
      check($sformatf("rst%0d count_done", s), cd[s], 0);
      check($sformatf("rst%0d mac_run", s), run[s], 0);
      check($sformatf("rst%0d mac_start", s), mstart[s], 0);
      check($sformatf("rst%0d mac_size", s), msize[s], NI);
    end
    check("rst hidden_a", hid_a, 0);
    check("rst hidden_b", hid_b, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      ndone += int'(done[0]) + int'(done[1]);
    end
    check("post_rst no_done", ndone, 0);
    check("post_rst mac_size", msize[1], NI);

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      dly[tbl[t].sel] = tbl[t].d;
      for (int i = 0; i < 4; i++) vals[tbl[t].sel][i] = tbl[t].v[i];
      run_frame(tbl[t].sel, 1'b0, 1'b0, $sformatf("tbl%0d", t));
      for (int i = 0; i < ((tbl[t].sel == 0) ? NA : NB); i++)
        check($sformatf("tbl%0d table_hidden%0d", t, i), get_h(tbl[t].sel, i), tbl[t].e[i]);
    end

    // Start accepted in DONE: timeout frame chained straight into a normal frame.
    dly[1] = -1;
    run_frame(1, 1'b0, 1'b1, "chain_a");
    dly[1] = 5;
    vals[1] = '{16'h0123, 16'h8123, 16'h4000, 16'hC000};
    run_frame(1, 1'b1, 1'b0, "chain_b");

    // Randomized frames against the reference model.
    for (int t = 0; t < 8; t++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      dly[sel] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
      for (int i = 0; i < 4; i++) vals[sel][i] = 16'($urandom);
      run_frame(sel, 1'b0, 1'b0, $sformatf("rnd%0d", t));
    end

    // Mid-frame start is ignored, then reset during RUN of neuron 1 aborts the frame.
    dly[0] = 16;
    vals[0] = '{16'h1000, 16'h2000, 16'h3000, 16'h0000};
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    r = 0; k = 0;
    while (k < 200 && !(run[0] && mstart[0] == NI)) begin
      @(negedge clk);
      k++;
    end
    check("abort reached_neuron1", k < 200, 1);
    check("abort hidden0_stored", hid_a[0], 16'h1000);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort start_ignored_start", mstart[0], NI);
    check("abort start_ignored_run", run[0], 1);
    rst = 1'b1;
    #1;
    check("abort mac_run", run[0], 0);
    check("abort busy", busy[0], 0);
    check("abort hidden", hid_a, 0);
    @(posedge clk);
    #1;
    check("abort mac_start", mstart[0], 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done[0]);
    end
    check("abort no_done", ndone, 0);
    check("abort idle", busy[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
